// File: rtl/param_datapath.sv
// Two-stage (EX, WB) register-file datapath with forwarding: one instruction per cycle, result one edge after accept.
// A held result (out_valid && !out_ready) freezes EX and drops instr_ready.
module param_datapath #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int PC_W  = 8,
  localparam int RW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [RW-1:0]    instr_rd,
  input  logic [RW-1:0]    instr_rs,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             carry,
  output logic             zero,
  output logic [PC_W-1:0]  pc
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_ACC = 3'b111;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             ov_q, ov_d;
  logic             e_valid_q, e_valid_d;
  logic [2:0]       e_op_q, e_op_d;
  logic [RW-1:0]    e_rd_q, e_rd_d;
  logic [WIDTH-1:0] e_a_q, e_a_d;
  logic [WIDTH-1:0] e_b_q, e_b_d;
  logic [WIDTH-1:0] e_i_q, e_i_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [WIDTH:0]   alu_wide;
  logic             e_move;
  logic             accept;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_wide = '0;
    case (e_op_q)
      OP_ADD: begin
        alu_wide = {1'b0, e_a_q} + {1'b0, e_b_q};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      OP_SUB: begin
        // top bit of the widened difference is the borrow
        alu_wide = {1'b0, e_a_q} - {1'b0, e_b_q};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      OP_AND: alu_res = e_a_q & e_b_q;
      OP_OR:  alu_res = e_a_q | e_b_q;
      OP_XOR: alu_res = e_a_q ^ e_b_q;
      OP_LDI: alu_res = e_i_q;
      OP_SHL: begin
        alu_res = {e_a_q[WIDTH-2:0], 1'b0};
        alu_c   = e_a_q[WIDTH-1];
      end
      OP_ACC: begin
        alu_wide = {1'b0, e_a_q} + {1'b0, e_i_q};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    e_move      = e_valid_q && (!ov_q || out_ready);
    instr_ready = !rst && (!e_valid_q || e_move);
    accept      = instr_valid && instr_ready;
    fwd_a       = (e_valid_q && (e_rd_q == instr_rd)) ? alu_res : regs_q[instr_rd];
    fwd_b       = (e_valid_q && (e_rd_q == instr_rs)) ? alu_res : regs_q[instr_rs];
  end

  always_comb begin
    regs_d    = regs_q;
    pc_d      = pc_q;
    dout_d    = dout_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    ov_d      = ov_q;
    e_valid_d = e_valid_q;
    e_op_d    = e_op_q;
    e_rd_d    = e_rd_q;
    e_a_d     = e_a_q;
    e_b_d     = e_b_q;
    e_i_d     = e_i_q;

    if (e_move) begin
      regs_d[e_rd_q] = alu_res;
      dout_d         = alu_res;
      carry_d        = alu_c;
      zero_d         = (alu_res == '0);
      ov_d           = 1'b1;
    end else if (out_ready) begin
      ov_d = 1'b0;
    end

    if (accept) begin
      e_valid_d = 1'b1;
      e_op_d    = instr_op;
      e_rd_d    = instr_rd;
      e_a_d     = fwd_a;
      e_b_d     = fwd_b;
      e_i_d     = data_in;
      pc_d      = pc_q + PC_W'(1);
    end else if (e_move) begin
      e_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pc_q      <= '0;
      dout_q    <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      ov_q      <= 1'b0;
      e_valid_q <= 1'b0;
      e_op_q    <= '0;
      e_rd_q    <= '0;
      e_a_q     <= '0;
      e_b_q     <= '0;
      e_i_q     <= '0;
    end else begin
      regs_q    <= regs_d;
      pc_q      <= pc_d;
      dout_q    <= dout_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      ov_q      <= ov_d;
      e_valid_q <= e_valid_d;
      e_op_q    <= e_op_d;
      e_rd_q    <= e_rd_d;
      e_a_q     <= e_a_d;
      e_b_q     <= e_b_d;
      e_i_q     <= e_i_d;
    end
  end

  assign out_valid = ov_q;
  assign data_out  = dout_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_param_datapath.sv
// Bench for param_datapath: an in-order architectural model predicts every result, plus hand-computed pins.
module tb_param_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [2:0]  instr_op = '0;
  logic [2:0]  instr_rd = '0;
  logic [2:0]  instr_rs = '0;
  logic [15:0] data_in = '0;
  logic        out_ready = 1'b1;
  logic        sel = 1'b0;

  logic        r8, ov8, c8, z8;
  logic [7:0]  d8, pc8;
  logic        r16, ov16, c16, z16;
  logic [15:0] d16;
  logic [7:0]  pc16;

  always #5 clk = ~clk;

  param_datapath #(.WIDTH(8), .NREGS(4), .PC_W(8)) u_d8 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(r8),
    .instr_op(instr_op), .instr_rd(instr_rd[1:0]), .instr_rs(instr_rs[1:0]),
    .data_in(data_in[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .data_out(d8), .carry(c8), .zero(z8), .pc(pc8)
  );

  param_datapath #(.WIDTH(16), .NREGS(8), .PC_W(8)) u_d16 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(r16),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .data_in(data_in), .out_valid(ov16), .out_ready(out_ready),
    .data_out(d16), .carry(c16), .zero(z16), .pc(pc16)
  );

  logic        cur_ready, cur_ov, cur_c, cur_z;
  logic [15:0] cur_d;
  logic [7:0]  cur_pc;
  assign cur_ready = sel ? r16 : r8;
  assign cur_ov    = sel ? ov16 : ov8;
  assign cur_c     = sel ? c16 : c8;
  assign cur_z     = sel ? z16 : z8;
  assign cur_d     = sel ? d16 : {8'h00, d8};
  assign cur_pc    = sel ? pc16 : pc8;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Architectural model: each accepted instruction executes in program order on mregs.
  function automatic logic [16:0] ref_op(input int op, input int a, input int b, input int i, input int w);
    int m, r, c;
    m = 1 << w;
    c = 0;
    case (op)
      0: begin r = a + b; c = (r >= m) ? 1 : 0; r = r % m; end
      1: begin c = (a < b) ? 1 : 0; r = (a - b + m) % m; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = i;
      6: begin r = a * 2; c = (r >= m) ? 1 : 0; r = r % m; end
      7: begin r = a + i; c = (r >= m) ? 1 : 0; r = r % m; end
      default: r = 0;
    endcase
    return {c[0], r[15:0]};
  endfunction

  int          mregs [8];
  int          mpc;
  logic [17:0] expq [$];
  logic [17:0] obs [$];
  int          obs_cyc [$];
  logic        prev_stall;
  logic [17:0] prev_out;
  logic [17:0] e_item;
  logic [16:0] m_res;
  int          w, rdi, rsi, imm;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    w = sel ? 16 : 8;
    if (rst) begin
      for (int k = 0; k < 8; k++) mregs[k] = 0;
      mpc = 0;
      expq.delete();
      prev_stall = 1'b0;
    end else begin
      chk("pc", {24'd0, cur_pc}, mpc[31:0]);
      if (prev_stall && cur_ov)
        chk("stall_hold", {14'd0, cur_c, cur_z, cur_d}, {14'd0, prev_out});
      if (cur_ov && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e_item = expq.pop_front();
          chk("data_out", {16'd0, cur_d}, {16'd0, e_item[15:0]});
          chk("carry", {31'd0, cur_c}, {31'd0, e_item[17]});
          chk("zero", {31'd0, cur_z}, {31'd0, e_item[16]});
        end
        obs.push_back({cur_c, cur_z, cur_d});
        obs_cyc.push_back(cyc_cnt);
      end
      if (instr_valid && cur_ready) begin
        rdi = sel ? int'(instr_rd) : int'(instr_rd[1:0]);
        rsi = sel ? int'(instr_rs) : int'(instr_rs[1:0]);
        imm = sel ? int'(data_in) : int'(data_in[7:0]);
        m_res = ref_op(int'(instr_op), mregs[rdi], mregs[rsi], imm, w);
        expq.push_back({m_res[16], (m_res[15:0] == 16'd0), m_res[15:0]});
        mregs[rdi] = int'(m_res[15:0]);
        mpc = (mpc + 1) % 256;
      end
      prev_stall = cur_ov && !out_ready;
      prev_out   = {cur_c, cur_z, cur_d};
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [15:0] imm_v);
    bit acc;
    acc = 1'b0;
    instr_valid = 1'b1;
    instr_op = op;
    instr_rd = rd;
    instr_rs = rs;
    data_in = imm_v;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = cur_ready;
      cyc();
    end
    if (!acc) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    instr_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) cyc();
    chk("queue_drained", expq.size(), 32'd0);
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic pin(input string nm, input int idx, input logic [17:0] exp);
    if (idx >= obs.size()) chk({nm, "_missing"}, 32'd0, 32'd1);
    else chk(nm, {14'd0, obs[idx]}, {14'd0, exp});
  endtask

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, LDI = 3'd5, SHL = 3'd6, ACC = 3'd7;

  int base;

  initial begin
    do_reset();

    // reset mid-stream
    issue(LDI, 3'd1, 3'd0, 16'd9);
    issue(ADD, 3'd1, 3'd1, 16'd0);
    instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_in_rst", {31'd0, cur_ready}, 32'd0);
    cyc();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, cur_ov}, 32'd0);
    chk("rst_data_out", {16'd0, cur_d}, 32'd0);
    chk("rst_pc", {24'd0, cur_pc}, 32'd0);
    chk("ready_in_rst2", {31'd0, cur_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    base = obs.size();
    issue(LDI, 3'd0, 3'd0, 16'd7);
    issue(ADD, 3'd0, 3'd1, 16'd0);
    drain();
    pin("post_rst_ldi", base, {2'b00, 16'd7});
    pin("post_rst_r1_cleared", base + 1, {2'b00, 16'd7});

    // forwarding, back-to-back
    do_reset();
    base = obs.size();
    issue(LDI, 3'd0, 3'd0, 16'd5);
    issue(LDI, 3'd1, 3'd0, 16'd3);
    issue(ADD, 3'd0, 3'd1, 16'd0);
    issue(ADD, 3'd0, 3'd0, 16'd0);
    drain();
    pin("fwd_0", base, {2'b00, 16'd5});
    pin("fwd_1", base + 1, {2'b00, 16'd3});
    pin("fwd_2", base + 2, {2'b00, 16'd8});
    pin("fwd_3", base + 3, {2'b00, 16'd16});
    if (obs.size() >= base + 4) chk("fwd_consecutive", obs_cyc[base + 3] - obs_cyc[base], 32'd3);
    chk("fwd_pc", {24'd0, cur_pc}, 32'd4);

    // flags, overflow, shift, logic ops
    do_reset();
    base = obs.size();
    issue(LDI, 3'd0, 3'd0, 16'd8);
    issue(LDI, 3'd1, 3'd0, 16'd3);
    issue(SUB, 3'd1, 3'd0, 16'd0);
    issue(SUB, 3'd1, 3'd1, 16'd0);
    issue(LDI, 3'd2, 3'd0, 16'd200);
    issue(ACC, 3'd2, 3'd0, 16'd100);
    issue(LDI, 3'd3, 3'd0, 16'h81);
    issue(SHL, 3'd3, 3'd0, 16'd0);
    issue(XOR_, 3'd3, 3'd3, 16'd0);
    issue(AND_, 3'd2, 3'd0, 16'd0);
    issue(OR_, 3'd0, 3'd3, 16'hFF);
    drain();
    pin("sub_borrow", base + 2, {2'b10, 16'd251});
    pin("sub_self", base + 3, {2'b01, 16'd0});
    pin("acc_ovf", base + 5, {2'b10, 16'd44});
    pin("shl", base + 7, {2'b10, 16'd2});
    pin("xor_self", base + 8, {2'b01, 16'd0});
    pin("and", base + 9, {2'b00, 16'd8});

    // backpressure
    do_reset();
    base = obs.size();
    out_ready = 1'b0;
    issue(LDI, 3'd0, 3'd0, 16'd11);
    issue(LDI, 3'd1, 3'd0, 16'd22);
    instr_valid = 1'b1;
    instr_op = LDI;
    instr_rd = 3'd2;
    data_in = 16'd33;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready_low", {31'd0, cur_ready}, 32'd0);
      chk("bp_hold_data", {16'd0, cur_d}, 32'd11);
      cyc();
    end
    out_ready = 1'b1;
    issue(LDI, 3'd2, 3'd0, 16'd33);
    drain();
    pin("bp_0", base, {2'b00, 16'd11});
    pin("bp_1", base + 1, {2'b00, 16'd22});
    pin("bp_2", base + 2, {2'b00, 16'd33});
    chk("bp_pc", {24'd0, cur_pc}, 32'd3);

    // pc wrap
    do_reset();
    for (int k = 0; k < 256; k++) begin
      issue(LDI, 3'(k % 4), 3'd0, 16'(k));
      if (k == 254) chk("pc_255", {24'd0, cur_pc}, 32'd255);
    end
    chk("pc_wrap", {24'd0, cur_pc}, 32'd0);
    drain();

    // wide instance
    sel = 1'b1;
    do_reset();
    base = obs.size();
    issue(LDI, 3'd4, 3'd0, 16'd5);
    issue(LDI, 3'd7, 3'd0, 16'd3);
    issue(ADD, 3'd4, 3'd7, 16'd0);
    issue(ADD, 3'd4, 3'd4, 16'd0);
    issue(LDI, 3'd5, 3'd0, 16'd40000);
    issue(LDI, 3'd6, 3'd0, 16'd40000);
    issue(ADD, 3'd5, 3'd6, 16'd0);
    drain();
    pin("w16_fwd_2", base + 2, {2'b00, 16'd8});
    pin("w16_fwd_3", base + 3, {2'b00, 16'd16});
    pin("w16_add_ovf", base + 6, {2'b10, 16'd14464});
    chk("w16_pc", {24'd0, cur_pc}, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_datapath.md
Name: param_datapath

Overview:
- Parametrised successor to the 8-bit single-accumulator integrated datapath.
- Executes one instruction per cycle through a 2-stage pipeline (EX, WB) over an NREGS-entry register file, with 8 ALU ops, carry/zero flags, operand forwarding, a wrapping PC and valid/ready handshakes on both instruction and result sides.
- Sits between the instruction sequencer and the result consumer in the datapath subsystem.

Parameters:
- WIDTH, 8, datapath / register width in bits
- NREGS, 4, number of general registers; power of two, ≥2
- PC_W, 8, program counter width; wraps modulo 2^PC_W
- RW is derived, not a parameter: RW = $clog2(NREGS)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept (combinational)
- instr_op  in  3  opcode
- instr_rd  in  RW  destination and first source register
- instr_rs  in  RW  second source register
- data_in  in  WIDTH  immediate operand, sampled at acceptance
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- data_out  out  WIDTH  result of committed instruction
- carry  out  1  carry/borrow flag of committed instruction
- zero  out  1  data_out == 0
- pc  out  PC_W  count of accepted instructions

Behaviour:
- Reset (rst=1 at a rising edge) clears all registers, pc, data_out, carry, zero, out_valid and the EX valid bit, regardless of in-flight work. While rst=1, instr_ready=0.
- Opcodes, where A = reg[rd], B = reg[rs], I = data_in. All arithmetic is modulo 2^WIDTH.
  - 000 ADD: A+B, carry = carry-out
  - 001 SUB: A−B, carry = borrow (A<B)
  - 010 AND: A&B, carry = 0
  - 011 OR: A|B, carry = 0
  - 100 XOR: A^B, carry = 0
  - 101 LDI: I, carry = 0
  - 110 SHL: A<<1, carry = A[WIDTH-1]
  - 111 ACC: A+I, carry = carry-out
- Acceptance: occurs on an edge where instr_valid && instr_ready. The EX stage latches op, rd, A, B, I, and pc increments by 1 (wrapping 2^PC_W−1 → 0).
- Stage movement:
  - e_move = e_valid && (!out_valid || out_ready)
  - instr_ready = !rst && (!e_valid || e_move)
- Commit (on an edge with e_move):
  - reg[rd] ← result; data_out ← result; carry, zero updated; out_valid ← 1.
  - An out_ready handshake with no e_move clears out_valid.
- Latency: an instruction accepted at edge N appears on data_out after edge N+1 when unstalled. Throughput is 1 instruction per cycle.
- Forwarding: when the incoming instruction reads a register (rd or rs) equal to the EX instruction's rd, it takes the EX ALU result, not the register file value. This applies whether or not EX commits on the same edge.
- Stall: while out_valid && !out_ready, data_out, carry and zero hold stable and the EX contents hold. At most 2 instructions are in flight.
- rd == rs is legal (e.g. ADD r,r doubles; SUB r,r gives 0 with zero=1).
- instr_* and data_in are ignored when not accepted.
- All outputs are registered except instr_ready.

Test Plan:
- Reset mid-stream: issue 2 instructions, assert rst for 2 cycles → out_valid=0, data_out=0, pc=0, instr_ready=0 during rst; next LDI r0,7 commits 7 (not stale values).
- Forwarding: back-to-back LDI r0,5; LDI r1,3; ADD r0,r1; ADD r0,r0, out_ready=1 → data_out sequence 5,3,8,16 on consecutive cycles, pc=4.
- Flags: r0=8, r1=3; SUB r1,r0 → 251, carry=1, zero=0. SUB r1,r1 → 0, carry=0, zero=1.
- Overflow/shift: LDI r2,200; ACC r2 with data_in=100 → 44, carry=1. LDI r3,0x81; SHL r3 → 0x02, carry=1. XOR r3,r3 → 0, zero=1.
- Backpressure: out_ready=0 while offering 3 instructions → 2 accepted, instr_ready=0 after the second, data_out holds the first result. Raise out_ready → results emerge in order, third is accepted, pc=3.
- PC wrap: 256 accepted LDIs with PC_W=8 → pc returns to 0. Repeat the forwarding scenario with WIDTH=16, NREGS=8, ADD 40000+40000 → 14464, carry=1.
